// File: rtl/router_sync_pkg.sv
// Shared encodings and timeout constants for the router synchronizer.
package router_sync_pkg;
  typedef enum logic [1:0] {
    PORT0   = 2'b00,
    PORT1   = 2'b01,
    PORT2   = 2'b10,
    INVALID = 2'b11
  } addr_e;

  localparam int NUM_PORTS      = 3;
  localparam int TIMEOUT_CYCLES = 30;
  localparam int CNT_W          = 5;

  // One-hot FIFO select; the invalid address selects nothing.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input addr_e a);
    case (a)
      PORT0:   port_onehot = 3'b001;
      PORT1:   port_onehot = 3'b010;
      PORT2:   port_onehot = 3'b100;
      default: port_onehot = 3'b000;
    endcase
  endfunction
endpackage

// File: rtl/router_sync_timer.sv
// Per-port stall timer: pulses soft_reset after 30 consecutive unread-valid cycles.
module router_sync_timer
  import router_sync_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic read_enb,
  output logic soft_reset
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sr  <= 1'b0;
    end else begin
      r_sr <= 1'b0;
      if (!vld || read_enb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        // Wrap so a continuing stall re-fires every TIMEOUT_CYCLES.
        r_cnt <= '0;
        r_sr  <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign soft_reset = r_sr;
endmodule

// File: rtl/router_sync.sv
// Router synchronizer: latches destination, steers FIFO writes, flags stalled outputs.
module router_sync
  import router_sync_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       detect_add,
  input  logic       write_en_reg,
  input  logic [1:0] data_in,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic [2:0] write_en,
  output logic       vld_out_0,
  output logic       soft_reset_0,
  output logic       vld_out_1,
  output logic       soft_reset_1,
  output logic       vld_out_2,
  output logic       soft_reset_2,
  output logic       fifo_full
);
  addr_e                r_addr;
  addr_e                w_addr;
  logic [NUM_PORTS-1:0] w_vld;
  logic [NUM_PORTS-1:0] w_rd;
  logic [NUM_PORTS-1:0] w_sr;

  always_ff @(posedge clk) begin
    if (rst)             r_addr <= PORT0;
    else if (detect_add) r_addr <= addr_e'(data_in);
  end

  // Steering follows address 00 for the whole reset window, not just after the first edge.
  assign w_addr = rst ? PORT0 : r_addr;

  assign write_en = write_en_reg ? port_onehot(w_addr) : 3'b000;

  always_comb begin
    fifo_full = 1'b0;
    case (w_addr)
      PORT0:   fifo_full = full_0;
      PORT1:   fifo_full = full_1;
      PORT2:   fifo_full = full_2;
      default: fifo_full = 1'b0;
    endcase
  end

  assign w_vld = ~{empty_2, empty_1, empty_0};
  assign w_rd  = {read_enb_2, read_enb_1, read_enb_0};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_tmr
    router_sync_timer u_tmr (
      .clk        (clk),
      .rst        (rst),
      .vld        (w_vld[g]),
      .read_enb   (w_rd[g]),
      .soft_reset (w_sr[g])
    );
  end

  assign vld_out_0    = w_vld[0];
  assign vld_out_1    = w_vld[1];
  assign vld_out_2    = w_vld[2];
  assign soft_reset_0 = w_sr[0];
  assign soft_reset_1 = w_sr[1];
  assign soft_reset_2 = w_sr[2];
endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: address steering, valid tracking and stall timeouts.
module tb_router_sync;
  logic       clk = 1'b0;
  logic       rst, detect_add, write_en_reg;
  logic [1:0] data_in;
  logic       full_0, full_1, full_2;
  logic       empty_0, empty_1, empty_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [2:0] write_en;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       fifo_full;

  int n_cmp = 0;
  int n_err = 0;

  router_sync dut (
    .clk(clk), .rst(rst), .detect_add(detect_add), .write_en_reg(write_en_reg),
    .data_in(data_in), .full_0(full_0), .full_1(full_1), .full_2(full_2),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .write_en(write_en), .vld_out_0(vld_out_0), .soft_reset_0(soft_reset_0),
    .vld_out_1(vld_out_1), .soft_reset_1(soft_reset_1),
    .vld_out_2(vld_out_2), .soft_reset_2(soft_reset_2), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sr3();
    return {5'd0, soft_reset_2, soft_reset_1, soft_reset_0};
  endfunction

  initial begin
    rst = 1'b1; detect_add = 1'b0; write_en_reg = 1'b0; data_in = 2'b00;
    {full_2, full_1, full_0}             = 3'b000;
    {empty_2, empty_1, empty_0}          = 3'b111;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;

    // Reset window
    tick(); tick();
    chk("rst_sr", sr3(), 8'h0);
    write_en_reg = 1'b1; full_0 = 1'b1; #1;
    chk("rst_we", {5'd0, write_en}, 8'h1);
    chk("rst_ff", {7'd0, fifo_full}, 8'h1);
    full_0 = 1'b0; #1;
    chk("rst_ff0", {7'd0, fifo_full}, 8'h0);

    // Latch port 2; same-cycle write still uses old address
    rst = 1'b0; tick();
    detect_add = 1'b1; data_in = 2'b10; full_2 = 1'b1; #1;
    chk("old_addr_we", {5'd0, write_en}, 8'h1);
    tick(); detect_add = 1'b0; #1;
    chk("p2_we", {5'd0, write_en}, 8'h4);
    chk("p2_ff", {7'd0, fifo_full}, 8'h1);

    // Port 0 with port 1 full
    detect_add = 1'b1; data_in = 2'b00; full_1 = 1'b1;
    tick(); detect_add = 1'b0; #1;
    chk("p0_we", {5'd0, write_en}, 8'h1);
    chk("p0_ff", {7'd0, fifo_full}, 8'h0);
    write_en_reg = 1'b0; #1;
    chk("p0_we_off", {5'd0, write_en}, 8'h0);

    // Port 1
    write_en_reg = 1'b1; detect_add = 1'b1; data_in = 2'b01;
    tick(); detect_add = 1'b0; #1;
    chk("p1_we", {5'd0, write_en}, 8'h2);
    chk("p1_ff", {7'd0, fifo_full}, 8'h1);

    // Invalid address ignores all full flags
    {full_2, full_1, full_0} = 3'b111;
    detect_add = 1'b1; data_in = 2'b11;
    tick(); detect_add = 1'b0; #1;
    chk("inv_we", {5'd0, write_en}, 8'h0);
    chk("inv_ff", {7'd0, fifo_full}, 8'h0);
    write_en_reg = 1'b0; {full_2, full_1, full_0} = 3'b000;

    // Valid tracking; reads held so timers stay idle
    {read_enb_2, read_enb_1, read_enb_0} = 3'b111;
    {empty_2, empty_1, empty_0} = 3'b010; #1;
    chk("vld_a", {5'd0, vld_out_2, vld_out_1, vld_out_0}, 8'h5);
    {empty_2, empty_1, empty_0} = 3'b101; #1;
    chk("vld_b", {5'd0, vld_out_2, vld_out_1, vld_out_0}, 8'h2);
    tick();
    chk("vld_sr", sr3(), 8'h0);

    // Ports 0 and 1 stall 60 cycles concurrently: pulses at 30 and 60
    {empty_2, empty_1, empty_0} = 3'b100;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    for (int i = 1; i <= 60; i++) begin
      tick();
      chk($sformatf("stall01_c%0d", i), sr3(), (i == 30 || i == 60) ? 8'h3 : 8'h0);
    end
    {empty_2, empty_1, empty_0} = 3'b111;
    tick();

    // Port 2: read interrupts count, then 30 more stalls to fire
    empty_2 = 1'b0;
    for (int i = 1; i <= 20; i++) tick();
    chk("p2_pre_rd", sr3(), 8'h0);
    read_enb_2 = 1'b1; tick();
    chk("p2_rd", sr3(), 8'h0);
    read_enb_2 = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk($sformatf("p2_c%0d", i), sr3(), (i == 30) ? 8'h4 : 8'h0);
    end
    empty_2 = 1'b1; tick();

    // Reset mid-count aborts the timeout
    empty_0 = 1'b0;
    for (int i = 1; i <= 20; i++) tick();
    rst = 1'b1; tick();
    chk("mid_rst", sr3(), 8'h0);
    chk("mid_rst_vld", {7'd0, vld_out_0}, 8'h1);
    rst = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk($sformatf("post_rst_c%0d", i), sr3(), (i == 30) ? 8'h1 : 8'h0);
    end
    empty_0 = 1'b1; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
